// File: rtl/alu_4.sv
// Four-bit add/sub/and/or ALU with a registered 5-bit result.
// Define ALU_4_FLAGS_EN to add a registered zero flag output.
module alu_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] opcode,
`ifdef ALU_4_FLAGS_EN
  output logic       zero,
`endif
  output logic [4:0] op
);

  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_SUB = 2'b01;
  localparam logic [1:0] OPC_AND = 2'b10;
  localparam logic [1:0] OPC_OR  = 2'b11;

  logic [4:0] op_d;
  logic [4:0] op_q;

  // Operands are zero-extended so bit 4 carries the carry-out (ADD) or borrow (SUB).
  always_comb begin
    op_d = 5'd0;
    unique case (opcode)
      OPC_ADD: op_d = {1'b0, a} + {1'b0, b};
      OPC_SUB: op_d = {1'b0, a} - {1'b0, b};
      OPC_AND: op_d = {1'b0, a & b};
      OPC_OR:  op_d = {1'b0, a | b};
      default: op_d = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= 5'd0;
    end else begin
      op_q <= op_d;
    end
  end

  assign op = op_q;

`ifdef ALU_4_FLAGS_EN
  logic zero_d;
  logic zero_q;

  // Flag describes the value being loaded into op_q, so both flops stay aligned.
  always_comb begin
    zero_d = (op_d == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_4.sv
// Self-checking bench for alu_4: directed cases plus a randomized sweep
// against an arithmetic reference model, with a mid-stream reset pulse.
module tb_alu_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] opcode;
  logic [4:0] op;
`ifdef ALU_4_FLAGS_EN
  logic       zero;
`endif

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  alu_4 dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .opcode (opcode),
`ifdef ALU_4_FLAGS_EN
    .zero   (zero),
`endif
    .op     (op)
  );

  // Clock and reset-free default inputs
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp_val);
    checks++;
    if (obs !== exp_val) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
    end
  endtask

  // Reference model: plain integer arithmetic reduced modulo 32.
  function automatic logic [4:0] ref_model(input int ai, input int bi, input int opc);
    int r;
    case (opc)
      0:       r = ai + bi;
      1:       r = (ai - bi + 32) % 32;
      2:       r = ai & bi;
      default: r = ai | bi;
    endcase
    return 5'(r);
  endfunction

  // Driver: apply inputs, push the expectation, clock once, then compare.
  task automatic step(input string tag, input logic r, input logic [3:0] ai,
                      input logic [3:0] bi, input logic [1:0] oc, input logic [4:0] exp_val);
    logic [4:0] e;
    rst    = r;
    a      = ai;
    b      = bi;
    opcode = oc;
    exp_q.push_back(exp_val);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, op, e);
`ifdef ALU_4_FLAGS_EN
    check_eq({tag, "_zero"}, {4'd0, zero}, {4'd0, (e == 5'd0)});
`endif
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic [4:0] ev;
    rst = 1'b1;
    a = 4'd0;
    b = 4'd0;
    opcode = 2'b00;

    // Reset held two cycles with a full-scale add pending
    step("reset_0", 1'b1, 4'hf, 4'hf, 2'b00, 5'd0);
    step("reset_1", 1'b1, 4'hf, 4'hf, 2'b00, 5'd0);
    step("release_add", 1'b0, 4'hf, 4'hf, 2'b00, 5'd30);

    step("zero_add", 1'b0, 4'd0, 4'd0, 2'b00, 5'd0);

    step("sweep_add", 1'b0, 4'b0100, 4'b1101, 2'b00, 5'd17);
    step("sweep_sub", 1'b0, 4'b0100, 4'b1101, 2'b01, 5'd23);
    step("sweep_and", 1'b0, 4'b0100, 4'b1101, 2'b10, 5'd4);
    step("sweep_or",  1'b0, 4'b0100, 4'b1101, 2'b11, 5'd13);

    step("sub_no_borrow", 1'b0, 4'd13, 4'd4, 2'b01, 5'd9);
    check_eq("sub_no_borrow_bit4", {4'd0, op[4]}, 5'd0);
    step("sub_equal", 1'b0, 4'd5, 4'd5, 2'b01, 5'd0);
    step("sub_0_minus_15", 1'b0, 4'd0, 4'd15, 2'b01, 5'd17);

    // Random sweep, 20 pairs per opcode, reset pulse in the middle
    for (int opc = 0; opc < 4; opc++) begin
      for (int i = 0; i < 20; i++) begin
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        if (opc == 2 && i == 0) begin
          step("rand_reset", 1'b1, ra, rb, 2'(opc), 5'd0);
        end
        ev = ref_model(int'(ra), int'(rb), opc);
        step($sformatf("rand_op%0d_%0d", opc, i), 1'b0, ra, rb, 2'(opc), ev);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
